// File: rtl/video_timing_pkg.sv
// Shared types and frame-geometry constants for the video timing generator.
// Build option: VTG_FIELD_ALT_EN (see video_timing_gen.sv).
package video_timing_pkg;

    typedef logic [8:0] line_t;
    typedef logic [7:0] dot_t;

    typedef struct packed {
        logic hsync;
        logic hblank;
        logic vsync;
        logic vblank;
    } vsig_t;

    // Horizontal geometry, in color clocks
    localparam dot_t H_TOTAL     = 8'd228;
    localparam dot_t H_BLANK     = 8'd68;
    localparam dot_t HSYNC_START = 8'd20;
    localparam dot_t HSYNC_END   = 8'd36;

    // Vertical geometry, in lines
    localparam line_t NTSC_LINES  = 9'd262;
    localparam line_t PAL_LINES   = 9'd312;
    localparam line_t VSYNC_LINES = 9'd3;
    localparam line_t NTSC_VB_END = 9'd19;
    localparam line_t PAL_VB_END  = 9'd23;
    localparam line_t NTSC_VIS    = 9'd240;
    localparam line_t PAL_VIS     = 9'd288;

    // Decode of dot 0, line 0: the state every frame starts in
    localparam vsig_t VSIG_RESET = '{hsync: 1'b0, hblank: 1'b1, vsync: 1'b1, vblank: 1'b1};

    // Last line index of a standard-length frame
    function automatic line_t last_line(input logic pal);
        return pal ? (PAL_LINES - 9'd1) : (NTSC_LINES - 9'd1);
    endfunction

    // First visible line
    function automatic line_t vb_end(input logic pal);
        return pal ? PAL_VB_END : NTSC_VB_END;
    endfunction

    // First line of the bottom blanking region
    function automatic line_t vis_end(input logic pal);
        return pal ? (PAL_VB_END + PAL_VIS) : (NTSC_VB_END + NTSC_VIS);
    endfunction

endpackage

// File: rtl/vtg_decode.sv
// Combinational decode of dot/line counters into sync and blank levels.
module vtg_decode
    import video_timing_pkg::*;
(
    input  dot_t  h_count,
    input  line_t v_count,
    input  logic  pal,
    output vsig_t sig
);

    // Window compares on the counter values presented
    always_comb begin
        sig        = '0;
        sig.hblank = (h_count < H_BLANK);
        sig.hsync  = (h_count >= HSYNC_START) && (h_count < HSYNC_END);
        sig.vsync  = (v_count < VSYNC_LINES);
        // Any line past the visible region is blanked, including an extra alternate-field line
        sig.vblank = (v_count < vb_end(pal)) || (v_count >= vis_end(pal));
    end

endmodule

// File: rtl/video_timing_gen.sv
// TIA-style raw sync generator driven by the color-clock enable.
// Build option: define VTG_FIELD_ALT_EN to add output f1 and make every
// other frame one line longer.
module video_timing_gen
    import video_timing_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       oclk,
    input  logic       pal_in,
    output logic       hsync,
    output logic       hblank,
    output logic       vsync,
    output logic       vblank,
    output logic [7:0] h_count,
    output logic [8:0] v_count,
    output logic       frame_start,
    output logic       pal_active
`ifdef VTG_FIELD_ALT_EN
    ,
    output logic       f1
`endif
);

    dot_t  h_q, h_d;
    line_t v_q, v_d;
    logic  pal_q, pal_d;
    logic  frame_start_q;
    vsig_t sig_q, sig_d;
    line_t line_end;
    logic  h_wrap, v_wrap, frame_wrap;

`ifdef VTG_FIELD_ALT_EN
    logic f1_q;
`endif

    // Next-state counters; the pal latch only moves at the frame wrap
    always_comb begin
        line_end = last_line(pal_q);
`ifdef VTG_FIELD_ALT_EN
        if (f1_q) begin
            line_end = line_end + 9'd1;
        end
`endif
        h_wrap     = (h_q == (H_TOTAL - 8'd1));
        v_wrap     = (v_q == line_end);
        frame_wrap = h_wrap && v_wrap;
        h_d        = h_wrap ? '0 : (h_q + 8'd1);
        v_d        = v_q;
        pal_d      = pal_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : (v_q + 9'd1);
        end
        if (frame_wrap) begin
            pal_d = pal_in;
        end
    end

    // Outputs are decoded from next-state values so they align with the counters
    vtg_decode u_decode (
        .h_count (h_d),
        .v_count (v_d),
        .pal     (pal_d),
        .sig     (sig_d)
    );

    // State update, qualified by the color-clock enable
    always_ff @(posedge clk) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            pal_q         <= 1'b0;
            sig_q         <= VSIG_RESET;
            frame_start_q <= 1'b0;
`ifdef VTG_FIELD_ALT_EN
            f1_q          <= 1'b0;
`endif
        end else begin
            frame_start_q <= 1'b0;
            if (oclk) begin
                h_q           <= h_d;
                v_q           <= v_d;
                pal_q         <= pal_d;
                sig_q         <= sig_d;
                frame_start_q <= frame_wrap;
`ifdef VTG_FIELD_ALT_EN
                if (frame_wrap) begin
                    f1_q <= ~f1_q;
                end
`endif
            end
        end
    end

    assign hsync       = sig_q.hsync;
    assign hblank      = sig_q.hblank;
    assign vsync       = sig_q.vsync;
    assign vblank      = sig_q.vblank;
    assign h_count     = h_q;
    assign v_count     = v_q;
    assign frame_start = frame_start_q;
    assign pal_active  = pal_q;
`ifdef VTG_FIELD_ALT_EN
    assign f1          = f1_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen.
module tb_video_timing_gen;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oclk = 1'b0;
    logic       pal_in = 1'b0;
    logic       hsync, hblank, vsync, vblank, frame_start, pal_active;
    logic [7:0] h_count;
    logic [8:0] v_count;
`ifdef VTG_FIELD_ALT_EN
    logic       f1;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] em_h;
    logic [8:0] em_v;
    logic       em_pal, em_fs;
`ifdef VTG_FIELD_ALT_EN
    logic       em_f1;
`endif

    always #5 clk = ~clk;

    video_timing_gen dut (
        .clk         (clk),
        .reset       (reset),
        .oclk        (oclk),
        .pal_in      (pal_in),
        .hsync       (hsync),
        .hblank      (hblank),
        .vsync       (vsync),
        .vblank      (vblank),
        .h_count     (h_count),
        .v_count     (v_count),
        .frame_start (frame_start),
        .pal_active  (pal_active)
`ifdef VTG_FIELD_ALT_EN
        ,
        .f1          (f1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        oclk  = 1'b0;
        tick();
        reset = 1'b0;
        em_h   = '0;
        em_v   = '0;
        em_pal = 1'b0;
        em_fs  = 1'b0;
`ifdef VTG_FIELD_ALT_EN
        em_f1  = 1'b0;
`endif
    endtask

    // {hsync, hblank, vsync, vblank} expected for a dot/line
    function automatic logic [3:0] exp_sig(input int h, input int v, input logic pal);
        logic hs, hb, vs, vb;
        hs = (h >= 20) && (h < 36);
        hb = (h < 68);
        vs = (v < 3);
        vb = pal ? ((v < 23) || (v >= 311)) : ((v < 19) || (v >= 259));
        return {hs, hb, vs, vb};
    endfunction

    function automatic logic [22:0] exp_vec();
        return {em_h, em_v, exp_sig(int'(em_h), int'(em_v), em_pal), em_fs, em_pal};
    endfunction

    function automatic logic [22:0] act_vec();
        return {h_count, v_count, hsync, hblank, vsync, vblank, frame_start, pal_active};
    endfunction

    // Advance the model by one clk; en is the oclk level that edge consumed
    task automatic model_step(input logic en);
        int lines;
        em_fs = 1'b0;
        if (en) begin
            lines = em_pal ? 312 : 262;
`ifdef VTG_FIELD_ALT_EN
            if (em_f1) lines = lines + 1;
`endif
            if (em_h == 8'd227) begin
                em_h = '0;
                if (int'(em_v) == lines - 1) begin
                    em_v   = '0;
                    em_pal = pal_in;
                    em_fs  = 1'b1;
`ifdef VTG_FIELD_ALT_EN
                    em_f1  = ~em_f1;
`endif
                end else begin
                    em_v = em_v + 9'd1;
                end
            end else begin
                em_h = em_h + 8'd1;
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        oclk   = 1'b1;
        pal_in = 1'b1;
        tick();
        tick();
        checks++;
        if (h_count !== 8'd0 || v_count !== 9'd0) begin
            errors++;
            $display("FAIL reset_counters: got h=%0d v=%0d want h=0 v=0", h_count, v_count);
        end
        checks++;
        if ({hsync, hblank, vsync, vblank} !== 4'b0111) begin
            errors++;
            $display("FAIL reset_sync: got %b want 0111", {hsync, hblank, vsync, vblank});
        end
        checks++;
        if (pal_active !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got pal=%b fs=%b want 0 0", pal_active, frame_start);
        end
`ifdef VTG_FIELD_ALT_EN
        checks++;
        if (f1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_f1: got %b want 0", f1);
        end
`endif
        pal_in = 1'b0;
        do_reset();
    endtask

    task automatic test_first_line();
        int hb_dots = 0;
        int hs_dots = 0;
        do_reset();
        pal_in = 1'b0;
        oclk   = 1'b1;
        for (int i = 1; i <= 228; i++) begin
            tick();
            model_step(1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (errors < 20)
                    $display("FAIL first_line clk %0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (hblank === 1'b1) hb_dots++;
            if (hsync === 1'b1) hs_dots++;
        end
        checks++;
        if (h_count !== 8'd0 || v_count !== 9'd1) begin
            errors++;
            $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=1", h_count, v_count);
        end
        checks++;
        if (hb_dots != 68 || hs_dots != 16) begin
            errors++;
            $display("FAIL line_widths: got hblank=%0d hsync=%0d want 68 16", hb_dots, hs_dots);
        end
    endtask

    // NTSC frame with a mid-frame PAL request, the start of the PAL frame, then a reset
    task automatic test_frames_and_reset();
        int   rises = 0;
        int   fs_cnt = 0;
        int   vis_first = -1;
        int   vis_last = -1;
        int   vis_cnt = 0;
        int   vs_cnt = 0;
        int   pal_first = -1;
        int   budget;
        logic hb_prev;
        do_reset();
        pal_in  = 1'b0;
        oclk    = 1'b1;
        hb_prev = hblank;
        for (int n = 1; n <= 262 * 228; n++) begin
            tick();
            model_step(1'b1);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (errors < 20)
                    $display("FAIL ntsc_frame clk %0d: got %h want %h", n, act_vec(), exp_vec());
            end
            if (hblank === 1'b1 && hb_prev === 1'b0) rises++;
            hb_prev = hblank;
            if (frame_start === 1'b1) fs_cnt++;
            if (em_h == 8'd100) begin
                if (vblank === 1'b0) begin
                    if (vis_first < 0) vis_first = int'(em_v);
                    vis_last = int'(em_v);
                    vis_cnt++;
                end
                if (vsync === 1'b1) vs_cnt++;
            end
            if (em_v == 9'd100 && em_h == 8'd0) pal_in = 1'b1;
        end
        checks++;
        if (rises != 262 || fs_cnt != 1) begin
            errors++;
            $display("FAIL ntsc_events: got rises=%0d fs=%0d want 262 1", rises, fs_cnt);
        end
        checks++;
        if (vis_first != 19 || vis_last != 258 || vis_cnt != 240) begin
            errors++;
            $display("FAIL ntsc_visible: got %0d..%0d n=%0d want 19..258 n=240",
                     vis_first, vis_last, vis_cnt);
        end
        checks++;
        if (vs_cnt != 3) begin
            errors++;
            $display("FAIL ntsc_vsync_lines: got %0d want 3", vs_cnt);
        end
        checks++;
        if (h_count !== 8'd0 || v_count !== 9'd0 || frame_start !== 1'b1 || pal_active !== 1'b1)
        begin
            errors++;
            $display("FAIL frame_wrap: got h=%0d v=%0d fs=%b pal=%b want 0 0 1 1",
                     h_count, v_count, frame_start, pal_active);
        end
`ifdef VTG_FIELD_ALT_EN
        checks++;
        if (f1 !== 1'b1) begin
            errors++;
            $display("FAIL f1_toggle: got %b want 1", f1);
        end
`endif
        pal_in = 1'b0;
        budget = 0;
        while (!(em_v == 9'd30 && em_h == 8'd90) && budget < 8000) begin
            tick();
            model_step(1'b1);
            budget++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (errors < 20)
                    $display("FAIL pal_frame clk %0d: got %h want %h", budget, act_vec(), exp_vec());
            end
            if (em_h == 8'd100 && vblank === 1'b0 && pal_first < 0) pal_first = int'(em_v);
        end
        checks++;
        if (pal_first != 23 || pal_active !== 1'b1) begin
            errors++;
            $display("FAIL pal_visible_start: got line=%0d pal=%b want 23 1", pal_first, pal_active);
        end
        // Reset with the enable low must still take effect on the next edge
        reset = 1'b1;
        oclk  = 1'b0;
        tick();
        checks++;
        if (act_vec() !== {8'd0, 9'd0, 4'b0111, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset: got %h want %h", act_vec(), {8'd0, 9'd0, 4'b0111, 2'b00});
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (h_count !== 8'd0 || v_count !== 9'd0) begin
            errors++;
            $display("FAIL post_reset_hold: got h=%0d v=%0d want 0 0", h_count, v_count);
        end
        oclk = 1'b1;
        tick();
        checks++;
        if (h_count !== 8'd1 || v_count !== 9'd0 || pal_active !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_resume: got h=%0d v=%0d pal=%b want 1 0 0",
                     h_count, v_count, pal_active);
        end
        oclk = 1'b0;
    endtask

    task automatic test_slow_oclk();
        do_reset();
        pal_in = 1'b0;
        for (int c = 1; c <= 690; c++) begin
            oclk = (c % 3 == 0);
            tick();
            model_step(oclk);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (errors < 20)
                    $display("FAIL slow_oclk clk %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 683 || c == 684) begin
                checks++;
                if (v_count !== ((c == 684) ? 9'd1 : 9'd0)) begin
                    errors++;
                    $display("FAIL slow_line_span clk %0d: got v=%0d want %0d",
                             c, v_count, (c == 684) ? 1 : 0);
                end
            end
        end
        oclk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frames_and_reset();
        test_slow_oclk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
